// File: rtl/lane_shift_fifo_pkg.sv
// Shared constants for the lane shift FIFO banks used around the systolic array.
// Also holds the lane-slice helper that fixes the "lane 0 in the MSBs" packing.
package lane_shift_fifo_pkg;

  localparam int PSUM_WIDTH    = 20;
  localparam int ACT_WIDTH     = 8;
  localparam int DEFAULT_LANES = 16;
  localparam int PSUM_DEPTH    = 16;
  localparam int ACT_DEPTH     = 256;

  // MSB index of a lane's word in a packed bus; lane 0 occupies the top slice.
  function automatic int lane_msb(input int lane, input int lanes, input int width);
    return (lanes - lane) * width - 1;
  endfunction

endpackage

// File: rtl/lane_shift_reg.sv
// Single-lane DEPTH x WIDTH enabled shift chain; output is the last stage.
// Every stage carries an asynchronous clear, so in-flight data is dropped on reset.
module lane_shift_reg
  import lane_shift_fifo_pkg::*;
#(
  parameter int DEPTH = PSUM_DEPTH,
  parameter int WIDTH = PSUM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("lane_shift_reg: DEPTH must be >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] stage_reg [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_reg[k] <= '0;
      end
    end else if (en) begin
      stage_reg[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        stage_reg[k] <= stage_reg[k-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/lane_shift_fifo.sv
// Bank of LANES independent fixed-latency shift FIFOs sharing clock, reset and enable.
// Handles the packing of lane words onto din/dout; lane 0 sits in the MSBs.
module lane_shift_fifo
  import lane_shift_fifo_pkg::*;
#(
  parameter int DEPTH = PSUM_DEPTH,
  parameter int LANES = DEFAULT_LANES,
  parameter int WIDTH = PSUM_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [LANES*WIDTH-1:0] din,
  output logic [LANES*WIDTH-1:0] dout
);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      lane_shift_reg #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
      ) u_lane (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .din   (din[lane_msb(gi, LANES, WIDTH) -: WIDTH]),
        .dout  (dout[lane_msb(gi, LANES, WIDTH) -: WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_lane_shift_fifo.sv
// Scoreboard bench for lane_shift_fifo: a 16x16x20 instance and a 256x16x8 instance.
// The driver queues the expected dout per edge; a monitor pops and compares after each edge or reset.
module tb_lane_shift_fifo;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en_a = 1'b0;
  logic         en_b = 1'b0;
  logic [319:0] din_a = '0;
  logic [319:0] dout_a;
  logic [127:0] din_b = '0;
  logic [127:0] dout_b;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit           chk_a;
    logic [319:0] exp_a;
    bit           chk_l;
    logic [19:0]  l0;
    logic [19:0]  l15;
    bit           chk_b;
    logic [127:0] exp_b;
    string        tag;
  } ent_t;

  ent_t sb[$];

  lane_shift_fifo #(.DEPTH(16), .LANES(16), .WIDTH(20)) dut_a (
    .clk   (clk),
    .reset (reset),
    .en    (en_a),
    .din   (din_a),
    .dout  (dout_a)
  );

  lane_shift_fifo #(.DEPTH(256), .LANES(16), .WIDTH(8)) dut_b (
    .clk   (clk),
    .reset (reset),
    .en    (en_b),
    .din   (din_b),
    .dout  (dout_b)
  );

  always #5 clk = ~clk;

  function automatic ent_t mk(input bit ca, input logic [319:0] ea, input bit cl,
                              input logic [19:0] l0, input logic [19:0] l15,
                              input bit cb, input logic [127:0] eb, input string tag);
    ent_t e;
    e.chk_a = ca; e.exp_a = ea; e.chk_l = cl; e.l0 = l0; e.l15 = l15;
    e.chk_b = cb; e.exp_b = eb; e.tag = tag;
    return e;
  endfunction

  // Word j of the latency sequence: lane i carries -(i+1)*(j+1), 20-bit two's complement.
  function automatic logic [319:0] word_a(input int j);
    logic [319:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[(16-i)*20-1 -: 20] = 20'(-(i+1)*(j+1));
    return v;
  endfunction

  function automatic logic [319:0] fill_a(input logic [19:0] x);
    return {16{x}};
  endfunction

  function automatic logic [127:0] fill_b(input logic [7:0] x);
    return {16{x}};
  endfunction

  task automatic step(input bit ea, input logic [319:0] da, input bit eb,
                      input logic [127:0] db, input ent_t e);
    @(negedge clk);
    en_a = ea; din_a = da; en_b = eb; din_b = db;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    en_a = 1'b0; en_b = 1'b0;
    #2;
    sb.push_back(mk(1, '0, 0, '0, '0, 1, '0, tag));
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // Monitor: samples 1 time unit after every clock edge or reset assertion.
  initial begin
    ent_t e;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_a) begin
          total++;
          if (dout_a !== e.exp_a) begin
            bad++;
            $display("FAIL %s dout_a got=%h want=%h", e.tag, dout_a, e.exp_a);
          end
        end
        if (e.chk_l) begin
          total++;
          if (dout_a[319 -: 20] !== e.l0 || dout_a[19:0] !== e.l15) begin
            bad++;
            $display("FAIL %s lane0/lane15 got=%h/%h want=%h/%h", e.tag,
                     dout_a[319 -: 20], dout_a[19:0], e.l0, e.l15);
          end
        end
        if (e.chk_b) begin
          total++;
          if (dout_b !== e.exp_b) begin
            bad++;
            $display("FAIL %s dout_b got=%h want=%h", e.tag, dout_b, e.exp_b);
          end
        end
        $display("txn %s dout_a=%h dout_b=%h", e.tag, dout_a, dout_b);
      end
    end
  end

  initial begin
    logic [319:0] pk;
    int wait_cyc;

    // Asynchronous reset before the first clock edge.
    #2;
    sb.push_back(mk(1, '0, 0, '0, '0, 1, '0, "rst_async_init"));
    reset = 1'b1;
    #2;
    reset = 1'b0;

    // 15 enabled edges with nonzero din: zero-filled stages still draining.
    for (int e = 1; e <= 15; e++)
      step(1, fill_a(20'h3C3C3), 0, '0, mk(1, '0, 0, '0, '0, 0, '0, "rst_drain"));

    // Latency and ordering.
    do_reset("rst_pre_latency");
    for (int e = 1; e <= 30; e++) begin
      ent_t en_e;
      en_e = mk(1, (e >= 16) ? word_a(e - 16) : '0, 0, '0, '0, 0, '0, "latency");
      if (e == 16) begin en_e.chk_l = 1; en_e.l0 = 20'hFFFFF; en_e.l15 = 20'hFFFF0; end
      if (e == 17) begin en_e.chk_l = 1; en_e.l0 = 20'hFFFFE; en_e.l15 = 20'hFFFE0; end
      if (e == 30) begin en_e.chk_l = 1; en_e.l0 = 20'hFFFF1; en_e.l15 = 20'hFFF10; end
      step(1, word_a(e - 1), 0, '0, en_e);
    end

    // Enable low: output frozen at word 14 while din keeps changing.
    for (int k = 0; k < 30; k++)
      step(0, word_a(100 + k), 0, '0,
           mk(1, word_a(14), (k == 29), 20'hFFFF1, 20'hFFF10, 0, '0, "hold"));
    step(1, word_a(30), 0, '0, mk(1, word_a(15), 1, 20'hFFFF0, 20'hFFF00, 0, '0, "resume"));

    // Lane packing: only lane 0 nonzero.
    do_reset("rst_pre_pack");
    pk = {20'h12345, 300'b0};
    for (int e = 1; e <= 16; e++)
      step(1, pk, 0, '0, mk(1, (e == 16) ? pk : '0, (e == 16), 20'h12345, 20'h00000,
                           0, '0, "pack"));

    // Reset mid-stream discards the 0xAAAAA words.
    do_reset("rst_pre_mid");
    for (int e = 1; e <= 8; e++)
      step(1, fill_a(20'hAAAAA), 0, '0, mk(1, '0, 0, '0, '0, 0, '0, "mid_fill"));
    do_reset("rst_mid");
    for (int e = 1; e <= 16; e++)
      step(1, fill_a(20'h55555), 0, '0,
           mk(1, (e == 16) ? fill_a(20'h55555) : '0, 0, '0, '0, 0, '0, "mid_after"));

    // 256-deep 8-bit configuration: counter stream.
    do_reset("rst_pre_deep");
    for (int e = 1; e <= 270; e++)
      step(0, '0, 1, fill_b(8'(e - 1)),
           mk(0, '0, 0, '0, '0, 1, (e <= 255) ? '0 : fill_b(8'(e - 256)), "deep"));

    // Let the monitor drain the scoreboard, bounded.
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      #2;
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
